// File: rtl/sprite_pal_pkg.sv
// sprite_pal_pkg: shared types and constants for the sprite palette engine.
package sprite_pal_pkg;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;
    localparam logic [3:0] FULL_LEVEL = 4'hF;
    localparam rgb_t DEFAULT_PAL [8] = '{
        12'h000, 12'h0E1, 12'hECA, 12'h04E, 12'hE30, 12'h776, 12'h080, 12'h610
    };
endpackage

// File: rtl/sprite_pal_scale.sv
// sprite_pal_scale: scales one 4-bit colour channel by brightness (level+1)/16.
module sprite_pal_scale (
    input  logic [3:0] c,
    input  logic [3:0] level,
    output logic [3:0] y
);
    logic [3:0] unused_lsb;
    assign {y, unused_lsb} = {4'b0, c} * ({4'b0, level} + 8'd1);
endmodule

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine: banked writable palette, frame-stepped fade, 2-cycle registered lookup.
// Optional damage flash enabled by defining SPRITE_PAL_FLASH_EN.
module sprite_palette_engine
    import sprite_pal_pkg::*;
#(
    parameter int IDX_W    = 3,
    parameter int BANKS    = 4,
    parameter int FADE_DIV = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [$clog2(BANKS)-1:0] pix_bank,
    input  logic [IDX_W-1:0]         pix_index,
    input  logic                     wr_en,
    input  logic [$clog2(BANKS)-1:0] wr_bank,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [11:0]              wr_rgb,
    input  logic                     fade_req,
    input  logic                     fade_dir,
    input  logic                     flash_trig,
    input  logic [5:0]               flash_frames,
    output logic                     out_valid,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue,
    output logic                     transparent,
    output logic [3:0]               fade_level,
    output logic                     fade_busy,
    output logic                     fade_done,
    output logic                     flash_active
);
    localparam int CW = $clog2(FADE_DIV + 1);

    rgb_t        pal [BANKS][2**IDX_W];
    rgb_t        s1_rgb, s2_rgb;
    logic        s1_valid, s1_tr, flash_on;
    logic [3:0]  sr, sg, sb, level_n, tgt;
    logic [CW-1:0] cnt, cnt_n;
    fade_state_t state, state_n;
    logic        done_n;

    // Array read is registered alongside the write, so same-entry read sees old data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < BANKS; b++)
                for (int i = 0; i < 2**IDX_W; i++)
                    pal[b][i] <= (i < 8) ? DEFAULT_PAL[i % 8] : '0;
            s1_valid <= 1'b0;
            s1_tr    <= 1'b0;
            s1_rgb   <= '0;
        end else begin
            if (wr_en) pal[wr_bank][wr_index] <= wr_rgb;
            s1_valid <= pix_valid;
            s1_tr    <= (pix_index == '0);
            s1_rgb   <= pal[pix_bank][pix_index];
        end
    end

    sprite_pal_scale u_r (.c(s1_rgb.r), .level(fade_level), .y(sr));
    sprite_pal_scale u_g (.c(s1_rgb.g), .level(fade_level), .y(sg));
    sprite_pal_scale u_b (.c(s1_rgb.b), .level(fade_level), .y(sb));

    assign s2_rgb = s1_tr ? '0 : flash_on ? 12'hFFF : {sr, sg, sb};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            out_valid   <= s1_valid;
            transparent <= s1_tr;
            {red, green, blue} <= s2_rgb;
        end
    end

    assign tgt = (state == FADE_IN) ? FULL_LEVEL : 4'h0;

    always_comb begin
        state_n = state;
        level_n = fade_level;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (fade_req) begin
                state_n = fade_dir ? FADE_IN : FADE_OUT;
                cnt_n   = '0;
            end
        end else if (frame_start) begin
            cnt_n = (cnt == CW'(FADE_DIV - 1)) ? '0 : cnt + 1'b1;
            if (cnt == CW'(FADE_DIV - 1)) begin
                level_n = (fade_level == tgt) ? fade_level :
                          (state == FADE_IN) ? fade_level + 4'd1 : fade_level - 4'd1;
                if (level_n == tgt) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            fade_level <= FULL_LEVEL;
            cnt        <= '0;
            fade_done  <= 1'b0;
        end else begin
            state      <= state_n;
            fade_level <= level_n;
            cnt        <= cnt_n;
            fade_done  <= done_n;
        end
    end

    assign fade_busy = (state != IDLE);

`ifdef SPRITE_PAL_FLASH_EN
    logic [5:0] flash_cnt;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) flash_cnt <= '0;
        else if (flash_trig) flash_cnt <= flash_frames;
        else if (frame_start && flash_cnt != '0) flash_cnt <= flash_cnt - 6'd1;
    end
    assign flash_on     = flash_cnt[0];
    assign flash_active = |flash_cnt;
`else
    logic unused_flash;
    assign unused_flash = ^{flash_trig, flash_frames};
    assign flash_on     = 1'b0;
    assign flash_active = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_palette_engine.sv
// tb_sprite_palette_engine: random and directed stimulus against a behavioural palette/fade/flash model.
module tb_sprite_palette_engine;
    localparam int IDX_W = 3, BANKS = 4, FADE_DIV = 2, BW = $clog2(BANKS);

    logic Clk = 0, Reset_n = 0;
    logic frame_start, pix_valid, wr_en, fade_req, fade_dir, flash_trig;
    logic [BW-1:0] pix_bank, wr_bank;
    logic [IDX_W-1:0] pix_index, wr_index;
    logic [11:0] wr_rgb;
    logic [5:0] flash_frames;
    logic out_valid, transparent, fade_busy, fade_done, flash_active;
    logic [3:0] red, green, blue, fade_level;

    sprite_palette_engine #(.IDX_W(IDX_W), .BANKS(BANKS), .FADE_DIV(FADE_DIV)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_bank(pix_bank), .pix_index(pix_index), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_index(wr_index), .wr_rgb(wr_rgb), .fade_req(fade_req), .fade_dir(fade_dir),
        .flash_trig(flash_trig), .flash_frames(flash_frames), .out_valid(out_valid),
        .red(red), .green(green), .blue(blue), .transparent(transparent),
        .fade_level(fade_level), .fade_busy(fade_busy), .fade_done(fade_done),
        .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    logic [11:0] defs [8] = '{12'h000, 12'h0E1, 12'hECA, 12'h04E, 12'hE30, 12'h776, 12'h080, 12'h610};
    logic [11:0] pal_m [BANKS][2**IDX_W];
    int level_m, fcnt_m, fl_m;
    bit busy_m, dir_m, done_m, p_valid, p_tr;
    logic [11:0] p_rgb;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] scale(input logic [3:0] c, input int lv);
        return 4'((int'(c) * (lv + 1)) / 16);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++)
            for (int i = 0; i < 2**IDX_W; i++) pal_m[b][i] = (i < 8) ? defs[i % 8] : 12'h000;
        level_m = 15; fcnt_m = 0; fl_m = 0;
        busy_m = 0; dir_m = 0; done_m = 0;
        p_valid = 0; p_tr = 0; p_rgb = 0;
    endtask

    task automatic idle();
        frame_start = 0; pix_valid = 0; pix_bank = 0; pix_index = 0;
        wr_en = 0; wr_bank = 0; wr_index = 0; wr_rgb = 0;
        fade_req = 0; fade_dir = 0; flash_trig = 0; flash_frames = 0;
    endtask

    task automatic rand_pix();
        pix_valid = 1'($urandom);
        pix_bank  = BW'($urandom);
        pix_index = IDX_W'($urandom);
    endtask

    task automatic look(input int b, input int i);
        pix_valid = 1; pix_bank = BW'(b); pix_index = IDX_W'(i);
    endtask

    // One clock: predict outputs for this edge, advance the model, then compare.
    task automatic cyc();
        bit ev, et;
        logic [11:0] er;
        int tgt;
        ev = p_valid; et = p_tr;
        er = et ? 12'h000 : (fl_m % 2 == 1) ? 12'hFFF :
             {scale(p_rgb[11:8], level_m), scale(p_rgb[7:4], level_m), scale(p_rgb[3:0], level_m)};
        p_valid = pix_valid; p_tr = (pix_index == 0); p_rgb = pal_m[pix_bank][pix_index];
        if (wr_en) pal_m[wr_bank][wr_index] = wr_rgb;
        done_m = 0;
        if (!busy_m) begin
            if (fade_req) begin busy_m = 1; dir_m = fade_dir; fcnt_m = 0; end
        end else if (frame_start) begin
            fcnt_m++;
            if (fcnt_m == FADE_DIV) begin
                fcnt_m = 0;
                tgt = dir_m ? 15 : 0;
                if (level_m != tgt) level_m += dir_m ? 1 : -1;
                if (level_m == tgt) begin busy_m = 0; done_m = 1; end
            end
        end
`ifdef SPRITE_PAL_FLASH_EN
        if (flash_trig) fl_m = flash_frames;
        else if (frame_start && fl_m > 0) fl_m--;
`endif
        @(posedge Clk); #1;
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("rgb", {red, green, blue}, er);
            chk("transparent", transparent, et);
        end
        chk("fade_level", fade_level, level_m);
        chk("fade_busy", fade_busy, busy_m);
        chk("fade_done", fade_done, done_m);
        chk("flash_active", flash_active, fl_m != 0);
    endtask

    initial begin
        int nfs;
        idle();
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_transparent", transparent, 0);
        chk("rst_level", fade_level, 15);
        chk("rst_busy", fade_busy, 0);
        chk("rst_done", fade_done, 0);
        chk("rst_flash", flash_active, 0);
        @(negedge Clk) Reset_n = 1;

        look(2, 4); cyc(); idle(); cyc();
        chk("lit_b2i4", {out_valid, transparent, red, green, blue}, {2'b10, 12'hE30});

        wr_en = 1; wr_bank = 1; wr_index = 3; wr_rgb = 12'h5A5; look(1, 3); cyc();
        idle(); look(1, 3); cyc();
        chk("lit_rd_old", {red, green, blue}, 12'h04E);
        idle(); cyc();
        chk("lit_rd_new", {red, green, blue}, 12'h5A5);

        idle(); fade_req = 1; fade_dir = 0; cyc();
        nfs = 0;
        while (nfs < 30) begin
            repeat (3) begin idle(); rand_pix(); cyc(); end
            idle(); rand_pix(); frame_start = 1; cyc(); nfs++;
            if (nfs == 5) begin
                idle(); fade_req = 1; fade_dir = 1; cyc();
                chk("lit_ignored_req", {fade_busy, fade_level}, {1'b1, 4'd13});
            end
            if (nfs == 16) begin
                idle(); look(0, 2); cyc(); idle(); cyc();
                chk("lit_lvl7_idx2", {fade_level, red, green, blue}, 16'h7765);
            end
        end
        chk("lit_done30", {fade_done, fade_busy, fade_level}, {2'b10, 4'd0});
        idle(); look(3, 0); cyc(); idle(); look(0, 2); cyc();
        chk("lit_tr_lvl0", {transparent, red, green, blue}, {1'b1, 12'h000});
        idle(); cyc();
        chk("lit_idx2_lvl0", {transparent, red, green, blue}, {1'b0, 12'h000});

        idle(); fade_req = 1; fade_dir = 1; cyc();
        repeat (12) begin idle(); frame_start = 1; cyc(); idle(); rand_pix(); cyc(); end
        chk("lit_fadein6", {fade_busy, fade_level}, {1'b1, 4'd6});
        idle();
        Reset_n = 0; #1;
        model_reset();
        chk("lit_midreset", {fade_busy, fade_level, out_valid}, {1'b0, 4'd15, 1'b0});
        @(negedge Clk) Reset_n = 1;
        look(1, 3); cyc(); idle(); cyc();
        chk("lit_pal_restored", {red, green, blue}, 12'h04E);

        flash_trig = 1; flash_frames = 3; cyc();
        idle(); look(0, 1); cyc(); idle(); cyc();
`ifdef SPRITE_PAL_FLASH_EN
        chk("lit_flash", {red, green, blue}, 12'hFFF);
`else
        chk("lit_noflash", {red, green, blue}, 12'h0E1);
`endif

        repeat (3000) begin
            idle(); rand_pix();
            wr_en = ($urandom % 4 == 0); wr_bank = BW'($urandom);
            wr_index = IDX_W'($urandom); wr_rgb = 12'($urandom);
            frame_start = ($urandom % 6 == 0);
            fade_req = ($urandom % 40 == 0); fade_dir = 1'($urandom);
            flash_trig = ($urandom % 60 == 0); flash_frames = 6'($urandom % 8);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
